// File: rtl/nrisc_run_controller.sv
// Run-control unit for the nRisc core: streams a program into instruction memory,
// pulses core reset, gates execution (free-run or single-step), and stops on halt or watchdog.
module nrisc_run_controller #(
  parameter int unsigned            ADDR_W      = 8,
  parameter int unsigned            INSTR_W     = 8,
  parameter logic [INSTR_W-1:0]     HALT_OPCODE = '0,
  parameter int unsigned            CNT_W       = 16,
  parameter int unsigned            MAX_CYCLES  = 0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               StepMode,
  input  logic               StepReq,
  input  logic               LoadValid,
  input  logic [INSTR_W-1:0] LoadData,
  input  logic               LoadLast,
  output logic               LoadReady,
  output logic               ImemWe,
  output logic [ADDR_W-1:0]  ImemAddr,
  output logic [INSTR_W-1:0] ImemWData,
  input  logic [ADDR_W-1:0]  PC,
  input  logic [INSTR_W-1:0] Instrucao,
  output logic               CoreReset,
  output logic               CoreEnable,
  output logic               Busy,
  output logic               Halted,
  output logic               TimedOut,
  output logic [ADDR_W-1:0]  StopPC,
  output logic [CNT_W-1:0]   CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRST, S_RUN, S_HALTED, S_TIMEOUT
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic              WD_ON    = (MAX_CYCLES != 0);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  ptr;
  logic               accept;
  logic               load_end;
  logic               start_ok;
  logic               halt_seen;
  logic               wd_hit;

  // Shared qualifiers: load acceptance, load termination, start acceptance, stop causes
  always_comb begin
    accept    = LoadValid & ((state == S_IDLE) | (state == S_LOAD));
    load_end  = accept & (LoadLast | (ptr == PTR_MAX));
    start_ok  = Start & (((state == S_IDLE) & ~LoadValid) |
                         (state == S_HALTED) | (state == S_TIMEOUT));
    halt_seen = (state == S_RUN) & (Instrucao == HALT_OPCODE);
    wd_hit    = WD_ON & CoreEnable & (CycleCount == WD_LAST);
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; in IDLE a concurrent load beats Start
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept)        state_next = load_end ? S_IDLE : S_LOAD;
        else if (start_ok) state_next = S_CRST;
      end
      S_LOAD:    if (load_end) state_next = S_IDLE;
      S_CRST:    state_next = S_RUN;
      S_RUN: begin
        if (halt_seen)   state_next = S_HALTED;
        else if (wd_hit) state_next = S_TIMEOUT;
      end
      S_HALTED, S_TIMEOUT: if (start_ok) state_next = S_CRST;
      default:   state_next = S_IDLE;
    endcase
  end

  // Combinational outputs; the halt instruction itself is never enabled
  always_comb begin
    LoadReady  = 1'b0;
    ImemWe     = 1'b0;
    ImemAddr   = ptr;
    ImemWData  = '0;
    CoreReset  = 1'b0;
    CoreEnable = 1'b0;
    Busy       = 1'b0;
    unique case (state)
      S_IDLE, S_LOAD: begin
        LoadReady = 1'b1;
        Busy      = (state == S_LOAD);
        ImemWe    = accept;
        if (accept) ImemWData = LoadData;
      end
      S_CRST: begin
        CoreReset = 1'b1;
        Busy      = 1'b1;
      end
      S_RUN: begin
        Busy       = 1'b1;
        CoreEnable = (Instrucao != HALT_OPCODE) & (~StepMode | StepReq);
      end
      default: ;
    endcase
  end

  // Load pointer, cycle counter and sticky stop status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr        <= '0;
      CycleCount <= '0;
      Halted     <= 1'b0;
      TimedOut   <= 1'b0;
      StopPC     <= '0;
    end else begin
      if (accept) ptr <= load_end ? '0 : ptr + ADDR_W'(1);
      if (start_ok) begin
        CycleCount <= '0;
        Halted     <= 1'b0;
        TimedOut   <= 1'b0;
        StopPC     <= '0;
      end else begin
        if (CoreEnable && CycleCount != CNT_MAX) CycleCount <= CycleCount + CNT_W'(1);
        if (halt_seen) begin
          Halted <= 1'b1;
          StopPC <= PC;
        end else if (wd_hit) begin
          TimedOut <= 1'b1;
          StopPC   <= PC;
        end
      end
    end
  end

endmodule

// File: tb/tb_nrisc_run_controller.sv
// Directed bench for nrisc_run_controller with a tiny behavioural core and instruction memory.
module tb_nrisc_run_controller;

  logic        Clock = 1'b0;
  logic        Reset, Start, StepMode, StepReq, LoadValid, LoadLast;
  logic [7:0]  LoadData;
  logic        LoadReady, ImemWe, CoreReset, CoreEnable, Busy, Halted, TimedOut;
  logic [7:0]  ImemAddr, ImemWData, PC, Instrucao, StopPC;
  logic [15:0] CycleCount;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  nrisc_run_controller #(
    .ADDR_W(8), .INSTR_W(8), .HALT_OPCODE(8'h00), .CNT_W(16), .MAX_CYCLES(10)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .StepMode(StepMode), .StepReq(StepReq),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(LoadReady),
    .ImemWe(ImemWe), .ImemAddr(ImemAddr), .ImemWData(ImemWData), .PC(PC),
    .Instrucao(Instrucao), .CoreReset(CoreReset), .CoreEnable(CoreEnable), .Busy(Busy),
    .Halted(Halted), .TimedOut(TimedOut), .StopPC(StopPC), .CycleCount(CycleCount)
  );

  // Core model: opcodes 8'b11xxxxxx jump to xxxxxx, everything else falls through
  logic [7:0] imem [256];
  always @(posedge Clock) if (ImemWe) imem[ImemAddr] <= ImemWData;
  assign Instrucao = imem[PC];
  always @(posedge Clock) begin
    if (Reset || CoreReset) PC <= 8'h00;
    else if (CoreEnable)    PC <= (Instrucao[7:6] == 2'b11) ? {2'b00, Instrucao[5:0]} : PC + 8'h01;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for Halted (sel=0) or TimedOut (sel=1)
  task automatic wait_stop(input string tag, input int sel, input int limit);
    int n = 0;
    while (((sel == 0) ? Halted : TimedOut) !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(tag, (sel == 0) ? Halted : TimedOut, 1);
  endtask

  task automatic load_word(input logic [7:0] data, input logic last, input logic [7:0] exp_addr,
                           input string tag);
    LoadValid = 1'b1; LoadData = data; LoadLast = last;
    #1;
    check({tag, "_we"}, ImemWe, 1);
    check({tag, "_addr"}, ImemAddr, exp_addr);
    tick();
    LoadValid = 1'b0; LoadLast = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] prog [4];
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h00;
    Reset = 1'b1; Start = 1'b0; StepMode = 1'b0; StepReq = 1'b0;
    LoadValid = 1'b0; LoadLast = 1'b0; LoadData = 8'h00;

    // 1: reset state
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("rst_loadready", LoadReady, 1);
    check("rst_busy", Busy, 0);
    check("rst_halted", Halted, 0);
    check("rst_timedout", TimedOut, 0);
    check("rst_count", CycleCount, 0);
    check("rst_enable", CoreEnable, 0);

    // 2: load four words, last one flagged
    for (int i = 0; i < 4; i++) begin
      load_word(prog[i], (i == 3), 8'(i), "load");
      if (i == 1) check("load_busy_mid", Busy, 1);
    end
    check("load_done_ready", LoadReady, 1);
    check("load_done_busy", Busy, 0);
    check("load_done_we", ImemWe, 0);
    check("imem_word2", imem[2], 8'h33);

    // 3: free run to halt at address 3
    Start = 1'b1;
    #1;
    check("start_idle_no_crst", CoreReset, 0);
    tick();
    Start = 1'b0;
    #1;
    check("crst_pulse", CoreReset, 1);
    check("crst_enable", CoreEnable, 0);
    tick();
    check("crst_single", CoreReset, 0);
    wait_stop("run_halt", 0, 20);
    check("run_count", CycleCount, 3);
    check("run_stoppc", StopPC, 3);
    check("run_enable_off", CoreEnable, 0);
    check("run_busy_off", Busy, 0);
    check("run_no_timeout", TimedOut, 0);
    check("halted_no_loadready", LoadReady, 0);

    // 4: single step, then switch back to free run
    StepMode = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("restart_clears_halt", Halted, 0);
    check("restart_clears_count", CycleCount, 0);
    tick();
    tick(); tick(); tick();
    check("step_idle_count", CycleCount, 0);
    check("step_idle_enable", CoreEnable, 0);
    StepReq = 1'b1;
    #1;
    check("step_enable", CoreEnable, 1);
    tick();
    StepReq = 1'b0;
    #1;
    check("step1_count", CycleCount, 1);
    tick(); tick(); tick();
    check("step1_hold", CycleCount, 1);
    check("step1_pc", PC, 1);
    StepReq = 1'b1;
    tick();
    StepReq = 1'b0;
    #1;
    check("step2_count", CycleCount, 2);
    check("step2_not_halted", Halted, 0);
    StepMode = 1'b0;
    wait_stop("step_run_halt", 0, 20);
    check("step_run_count", CycleCount, 3);
    check("step_run_stoppc", StopPC, 3);

    // 5: watchdog on a self-jump loop
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    load_word(8'h11, 1'b0, 8'd0, "wd_load0");
    load_word(8'hC1, 1'b1, 8'd1, "wd_load1");
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_stop("wd_timeout", 1, 40);
    check("wd_count", CycleCount, 10);
    check("wd_not_halted", Halted, 0);
    check("wd_stoppc", StopPC, 1);
    check("wd_enable_off", CoreEnable, 0);
    tick(); tick();
    check("wd_count_held", CycleCount, 10);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("wd_restart_flag", TimedOut, 0);
    check("wd_restart_count", CycleCount, 0);
    check("wd_restart_stoppc", StopPC, 0);
    wait_stop("wd_timeout2", 1, 40);
    check("wd_count2", CycleCount, 10);

    // 6: reset mid-run, then Start collides with a load in IDLE
    Start = 1'b1;
    tick();
    Start = 1'b0;
    begin
      int n = 0;
      while (CycleCount !== 16'd5 && n < 40) begin tick(); n++; end
    end
    check("mid_count5", CycleCount, 5);
    check("mid_busy", Busy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("abort_count", CycleCount, 0);
    check("abort_timedout", TimedOut, 0);
    check("abort_halted", Halted, 0);
    check("abort_enable", CoreEnable, 0);
    check("abort_busy", Busy, 0);
    check("abort_loadready", LoadReady, 1);
    check("abort_no_crst", CoreReset, 0);
    Start = 1'b1;
    load_word(8'h44, 1'b0, 8'd0, "collide");
    Start = 1'b0;
    #1;
    check("collide_no_crst", CoreReset, 0);
    check("collide_in_load", Busy, 1);
    load_word(8'h00, 1'b1, 8'd1, "collide_last");
    check("collide_idle", Busy, 0);

    // Full-depth load: acceptance at the last address returns to IDLE without wrapping
    for (int i = 0; i < 255; i++) begin
      LoadValid = 1'b1; LoadData = 8'h11; LoadLast = 1'b0;
      tick();
    end
    check("full_busy", Busy, 1);
    load_word(8'h11, 1'b0, 8'd255, "full_top");
    check("full_idle", Busy, 0);
    load_word(8'h22, 1'b1, 8'd0, "full_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
